// File: rtl/encore_axi_bridge_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : encore_axi_pkg                                             |
// | Description : Shared types and constants for the encore AXI bridge:      |
// |               FSM state encoding, AXI response codes, clog2 helper.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package encore_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_DATA = 3'd1,
    WR_RESP = 3'd2,
    TRIG    = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Ceiling log2 for elaboration-time sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/encore_axi_bridge_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : encore_axi_bridge_if                                       |
// | Description : AXI4 bus bundle (AW, W, B, AR, R channels) seen by the     |
// |               encore bridge. slave modport for the bridge, master        |
// |               modport for the host side.                                 |
// | Ports       : AW id/addr/len/valid/ready, W data/strb/last/valid/ready,  |
// |               B id/resp/valid/ready, AR id/addr/len/valid/ready,         |
// |               R id/data/resp/last/valid/ready                            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface encore_axi_bridge_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12,
  parameter int ID_W   = 16
);
  logic [ID_W-1:0]     s_axi_awid;
  logic [ADDR_W-1:0]   s_axi_awaddr;
  logic [7:0]          s_axi_awlen;
  logic                s_axi_awvalid;
  logic                s_axi_awready;

  logic [DATA_W-1:0]   s_axi_wdata;
  logic [DATA_W/8-1:0] s_axi_wstrb;
  logic                s_axi_wlast;
  logic                s_axi_wvalid;
  logic                s_axi_wready;

  logic [ID_W-1:0]     s_axi_bid;
  logic [1:0]          s_axi_bresp;
  logic                s_axi_bvalid;
  logic                s_axi_bready;

  logic [ID_W-1:0]     s_axi_arid;
  logic [ADDR_W-1:0]   s_axi_araddr;
  logic [7:0]          s_axi_arlen;
  logic                s_axi_arvalid;
  logic                s_axi_arready;

  logic [ID_W-1:0]     s_axi_rid;
  logic [DATA_W-1:0]   s_axi_rdata;
  logic [1:0]          s_axi_rresp;
  logic                s_axi_rlast;
  logic                s_axi_rvalid;
  logic                s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface
`default_nettype wire

// File: rtl/encore_axi_bridge_sync_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : encore_sync_pipe                                           |
// | Description : STAGES-deep flop chain bringing an asynchronous status     |
// |               word into the AXI clock domain.                            |
// | Ports       : clk, rst_n (async active-low), d (async in), q (synced)    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module encore_sync_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/encore_axi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : encore_axi_bridge                                          |
// | Description : AXI4 slave: INCR write bursts are pushed into an external  |
// |               FIFO, a write to TRIG_ADDR fires a turn2run pulse, reads   |
// |               return synchronised status words.                          |
// | Ports       : s_axi_aclk, s_axi_aresetn (async active-low),              |
// |               axi (AXI4 slave bundle), fifo_full/fifo_almost_full in,    |
// |               fifo_wr_data/fifo_wr_en out, syn_regs (async status in),   |
// |               turn2run (trigger pulse), debug_state (FSM encoding)       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module encore_axi_bridge
  import encore_axi_pkg::*;
#(
  parameter int              DATA_W      = 128,
  parameter int              ADDR_W      = 12,
  parameter int              ID_W        = 16,
  parameter int              NUM_SYN     = 2,
  parameter int              SYN_STAGES  = 2,
  parameter logic [ADDR_W-1:0] TRIG_ADDR = 'h080,
  parameter int              TRIG_CYCLES = 3
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  encore_axi_bridge_if.slave        axi,
  input  logic                      fifo_full,
  input  logic                      fifo_almost_full,
  output logic [DATA_W-1:0]         fifo_wr_data,
  output logic                      fifo_wr_en,
  input  logic [NUM_SYN*DATA_W-1:0] syn_regs,
  output logic                      turn2run,
  output logic [2:0]                debug_state
);

  localparam int SHIFT = clog2(DATA_W / 8);
  localparam int PCW   = (clog2(TRIG_CYCLES) < 1) ? 1 : clog2(TRIG_CYCLES);

  state_t              r_state, w_next;
  logic [ID_W-1:0]     r_awid, r_arid;
  logic [7:0]          r_awlen, r_cnt, r_arlen, r_rcnt;
  logic                r_err;
  logic [ADDR_W-1:0]   r_idx;
  logic [DATA_W-1:0]   r_rdata, r_fifo_data;
  logic [1:0]          r_rresp;
  logic                r_fifo_en, r_turn, r_trig_busy;
  logic [PCW-1:0]      r_pcnt;

  logic [DATA_W-1:0]   w_sync [NUM_SYN];
  logic                w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic                w_wready, w_last_beat, w_r_last, w_pulse_done;
  logic [ADDR_W-1:0]   w_look_idx;
  logic [DATA_W-1:0]   w_look_data;
  logic                w_look_ok;
  logic                w_unused;

  // Byte strobes are not honoured; every beat is a full FIFO word.
  assign w_unused = ^axi.s_axi_wstrb;

  for (genvar k = 0; k < NUM_SYN; k++) begin : g_sync
    encore_sync_pipe #(
      .WIDTH  (DATA_W),
      .STAGES (SYN_STAGES)
    ) u_sync (
      .clk   (s_axi_aclk),
      .rst_n (s_axi_aresetn),
      .d     (syn_regs[k*DATA_W +: DATA_W]),
      .q     (w_sync[k])
    );
  end

  assign w_last_beat  = (r_cnt == r_awlen);
  assign w_r_last     = (r_rcnt == r_arlen);
  assign w_pulse_done = (r_state == TRIG) && r_trig_busy && (r_pcnt == '0);

  // Write data is gated on both FIFO flags; a TRIG beat never reaches the FIFO
  // so it is accepted unconditionally until the pulse starts.
  assign w_wready = ((r_state == WR_DATA) && !fifo_full && !fifo_almost_full) ||
                    ((r_state == TRIG) && !r_trig_busy);

  assign w_aw_hs = (r_state == IDLE) && axi.s_axi_awvalid;
  assign w_ar_hs = (r_state == IDLE) && !axi.s_axi_awvalid && axi.s_axi_arvalid;
  assign w_w_hs  = w_wready && axi.s_axi_wvalid;
  assign w_b_hs  = (r_state == WR_RESP) && axi.s_axi_bready;
  assign w_r_hs  = (r_state == RD_DATA) && axi.s_axi_rready;

  // Status word index for the beat about to be loaded: the AR address while
  // idle, otherwise the following word of the current read burst.
  assign w_look_idx = (r_state == IDLE) ? (axi.s_axi_araddr >> SHIFT)
                                        : (r_idx + ADDR_W'(1));

  always_comb begin
    w_look_data = '0;
    w_look_ok   = 1'b0;
    for (int k = 0; k < NUM_SYN; k++) begin
      if (w_look_idx == ADDR_W'(k)) begin
        w_look_data = w_sync[k];
        w_look_ok   = 1'b1;
      end
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_state <= IDLE;
    else                r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    axi.s_axi_awready = 1'b0;
    axi.s_axi_arready = 1'b0;
    axi.s_axi_wready  = 1'b0;
    axi.s_axi_bvalid  = 1'b0;
    axi.s_axi_rvalid  = 1'b0;
    case (r_state)
      IDLE: begin
        axi.s_axi_awready = w_aw_hs;
        axi.s_axi_arready = w_ar_hs;
        if (w_aw_hs)      w_next = (axi.s_axi_awaddr == TRIG_ADDR) ? TRIG : WR_DATA;
        else if (w_ar_hs) w_next = RD_DATA;
      end
      WR_DATA: begin
        axi.s_axi_wready = w_wready;
        if (w_w_hs && w_last_beat) w_next = WR_RESP;
      end
      TRIG: begin
        axi.s_axi_wready = w_wready;
        if (w_pulse_done) w_next = WR_RESP;
      end
      WR_RESP: begin
        axi.s_axi_bvalid = 1'b1;
        if (w_b_hs) w_next = IDLE;
      end
      RD_DATA: begin
        axi.s_axi_rvalid = 1'b1;
        if (w_r_hs && w_r_last) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_awid      <= '0;
      r_arid      <= '0;
      r_awlen     <= '0;
      r_cnt       <= '0;
      r_arlen     <= '0;
      r_rcnt      <= '0;
      r_err       <= 1'b0;
      r_idx       <= '0;
      r_rdata     <= '0;
      r_rresp     <= RESP_OKAY;
      r_fifo_data <= '0;
      r_fifo_en   <= 1'b0;
      r_turn      <= 1'b0;
      r_trig_busy <= 1'b0;
      r_pcnt      <= '0;
    end else begin
      r_fifo_en <= 1'b0;

      if (w_aw_hs) begin
        r_awid      <= axi.s_axi_awid;
        r_awlen     <= axi.s_axi_awlen;
        r_cnt       <= '0;
        r_err       <= 1'b0;
        r_trig_busy <= 1'b0;
      end

      if (w_ar_hs) begin
        r_arid  <= axi.s_axi_arid;
        r_arlen <= axi.s_axi_arlen;
        r_rcnt  <= '0;
        r_idx   <= w_look_idx;
        r_rdata <= w_look_data;
        r_rresp <= w_look_ok ? RESP_OKAY : RESP_SLVERR;
      end

      if (w_w_hs) begin
        r_cnt <= r_cnt + 8'd1;
        if (axi.s_axi_wlast != w_last_beat) r_err <= 1'b1;
        if (r_state == WR_DATA) begin
          r_fifo_en   <= 1'b1;
          r_fifo_data <= axi.s_axi_wdata;
        end else begin
          // Trigger register only accepts single-beat writes; a burst is
          // drained, fires once on its final beat and reports SLVERR.
          if (r_awlen != 8'd0) r_err <= 1'b1;
          if (w_last_beat) begin
            r_trig_busy <= 1'b1;
            r_turn      <= 1'b1;
            r_pcnt      <= PCW'(TRIG_CYCLES - 1);
          end
        end
      end

      if ((r_state == TRIG) && r_trig_busy) begin
        if (r_pcnt == '0) r_turn <= 1'b0;
        else              r_pcnt <= r_pcnt - PCW'(1);
      end

      if (w_r_hs && !w_r_last) begin
        r_rcnt  <= r_rcnt + 8'd1;
        r_idx   <= w_look_idx;
        r_rdata <= w_look_data;
        r_rresp <= w_look_ok ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign axi.s_axi_bid   = r_awid;
  assign axi.s_axi_bresp = ((r_state == WR_RESP) && r_err) ? RESP_SLVERR : RESP_OKAY;
  assign axi.s_axi_rid   = r_arid;
  assign axi.s_axi_rdata = r_rdata;
  assign axi.s_axi_rresp = r_rresp;
  assign axi.s_axi_rlast = (r_state == RD_DATA) && w_r_last;

  assign fifo_wr_data = r_fifo_data;
  assign fifo_wr_en   = r_fifo_en;
  assign turn2run     = r_turn;
  assign debug_state  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_encore_axi_bridge.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_encore_axi_bridge                                       |
// | Description : Scoreboard bench for encore_axi_bridge: expected FIFO      |
// |               words, B and R responses are queued as stimulus is driven  |
// |               and popped as the bridge produces them.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_encore_axi_bridge;
  import encore_axi_pkg::*;

  localparam int DATA_W  = 128;
  localparam int ADDR_W  = 12;
  localparam int ID_W    = 16;
  localparam int NUM_SYN = 2;
  localparam logic [ADDR_W-1:0] TRIG_A = 12'h080;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  encore_axi_bridge_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W)) axi ();

  logic                      fifo_full, fifo_almost_full;
  logic [DATA_W-1:0]         fifo_wr_data;
  logic                      fifo_wr_en;
  logic [NUM_SYN*DATA_W-1:0] syn_regs;
  logic                      turn2run;
  logic [2:0]                debug_state;

  encore_axi_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .NUM_SYN(NUM_SYN),
    .SYN_STAGES(2), .TRIG_ADDR(TRIG_A), .TRIG_CYCLES(3)
  ) dut (
    .s_axi_aclk       (clk),
    .s_axi_aresetn    (rst_n),
    .axi              (axi),
    .fifo_full        (fifo_full),
    .fifo_almost_full (fifo_almost_full),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_wr_en       (fifo_wr_en),
    .syn_regs         (syn_regs),
    .turn2run         (turn2run),
    .debug_state      (debug_state)
  );

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_exp_t;

  logic [DATA_W-1:0] q_fifo [$];
  b_exp_t            q_b [$];
  r_exp_t            q_r [$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- monitors (sampled on the falling edge) ----------------
  bit                expect_push = 1'b0;
  bit                pend = 1'b0;
  bit                b_prev = 1'b0;
  bit                r_prev_last = 1'b0;
  bit                stall = 1'b0;
  logic [DATA_W-1:0] r_hold = '0;
  int                pulse_len = 0;
  int                pulse_cnt = 0;
  b_exp_t            be;
  r_exp_t            re;

  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 1'b0; b_prev = 1'b0; r_prev_last = 1'b0; stall = 1'b0; pulse_len = 0;
    end else begin
      // A push must follow each accepted W beat by exactly one clock.
      chk("push_en", fifo_wr_en, pend);
      if (fifo_wr_en) begin
        if (q_fifo.size() == 0) chk("push_unexpected", fifo_wr_en, 1'b0);
        else                    chk("push_data", fifo_wr_data, q_fifo.pop_front());
      end
      pend = axi.s_axi_wvalid && axi.s_axi_wready && expect_push;
      if ((fifo_full || fifo_almost_full) && expect_push)
        chk("wready_flag", axi.s_axi_wready, 1'b0);

      if (b_prev) chk("b_drop", axi.s_axi_bvalid, 1'b0);
      b_prev = 1'b0;
      if (axi.s_axi_bvalid && axi.s_axi_bready) begin
        if (q_b.size() == 0) chk("b_unexpected", axi.s_axi_bvalid, 1'b0);
        else begin
          be = q_b.pop_front();
          chk("bid", axi.s_axi_bid, be.id);
          chk("bresp", axi.s_axi_bresp, be.resp);
        end
        chk("b_in_pulse", turn2run, 1'b0);
        b_prev = 1'b1;
      end

      if (r_prev_last) chk("r_drop", axi.s_axi_rvalid, 1'b0);
      r_prev_last = 1'b0;
      if (axi.s_axi_rvalid) begin
        if (!axi.s_axi_rready) begin
          if (stall) chk("r_stable", axi.s_axi_rdata, r_hold);
          r_hold = axi.s_axi_rdata;
          stall  = 1'b1;
        end else begin
          stall = 1'b0;
          if (q_r.size() == 0) chk("r_unexpected", axi.s_axi_rvalid, 1'b0);
          else begin
            re = q_r.pop_front();
            chk("rid", axi.s_axi_rid, re.id);
            chk("rdata", axi.s_axi_rdata, re.data);
            chk("rresp", axi.s_axi_rresp, re.resp);
            chk("rlast", axi.s_axi_rlast, re.last);
            r_prev_last = axi.s_axi_rlast;
          end
        end
      end

      if (turn2run) begin
        pulse_len++;
        chk("bvalid_in_pulse", axi.s_axi_bvalid, 1'b0);
      end else if (pulse_len != 0) begin
        chk("pulse_len", pulse_len, 3);
        pulse_cnt++;
        pulse_len = 0;
      end
    end
  end

  // ---------------- driver tasks (drive just after the rising edge) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic aw_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len);
    int n;
    axi.s_axi_awid = id; axi.s_axi_awaddr = addr; axi.s_axi_awlen = 8'(len);
    axi.s_axi_awvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.s_axi_awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_accept", axi.s_axi_awready, 1'b1);
    tick();
    axi.s_axi_awvalid = 1'b0;
  endtask

  task automatic w_send(input logic [DATA_W-1:0] data, input bit last, input bit push);
    int n;
    axi.s_axi_wdata = data; axi.s_axi_wlast = last; axi.s_axi_wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.s_axi_wready && n < 100) begin @(negedge clk); n++; end
    chk("w_accept", axi.s_axi_wready, 1'b1);
    if (push && axi.s_axi_wready) q_fifo.push_back(data);
    tick();
    axi.s_axi_wvalid = 1'b0; axi.s_axi_wlast = 1'b0;
  endtask

  task automatic ar_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input int len);
    int n;
    axi.s_axi_arid = id; axi.s_axi_araddr = addr; axi.s_axi_arlen = 8'(len);
    axi.s_axi_arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!axi.s_axi_arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_accept", axi.s_axi_arready, 1'b1);
    tick();
    axi.s_axi_arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q_b.size() != 0 || q_r.size() != 0 || q_fifo.size() != 0 || debug_state != 3'd0)
           && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("drain", q_b.size() + q_r.size() + q_fifo.size(), 0);
    chk("idle_state", debug_state, 3'd0);
    tick();
  endtask

  task automatic write_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                             input int len, input int early, input int afull_idx,
                             input logic [DATA_W-1:0] base);
    bit trig;
    logic [1:0] resp;
    trig = (addr == TRIG_A);
    expect_push = !trig;
    resp = ((trig && len != 0) || early >= 0) ? RESP_SLVERR : RESP_OKAY;
    q_b.push_back('{id: id, resp: resp});
    aw_send(id, addr, len);
    for (int b = 0; b <= len; b++) begin
      w_send(base ^ DATA_W'(b), (b == len) || (b == early), !trig);
      if (b == afull_idx) begin
        fifo_almost_full = 1'b1;
        fork
          begin repeat (5) @(posedge clk); #1; fifo_almost_full = 1'b0; end
        join_none
      end
    end
    wait_idle();
  endtask

  task automatic read_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input int len, input bit hold_off);
    int idx;
    r_exp_t e;
    for (int b = 0; b <= len; b++) begin
      idx    = int'(addr) / (DATA_W / 8) + b;
      e.id   = id;
      e.data = (idx < NUM_SYN) ? syn_regs[idx*DATA_W +: DATA_W] : '0;
      e.resp = (idx < NUM_SYN) ? RESP_OKAY : RESP_SLVERR;
      e.last = (b == len);
      q_r.push_back(e);
    end
    if (hold_off) axi.s_axi_rready = 1'b0;
    ar_send(id, addr, len);
    if (hold_off) begin
      repeat (3) tick();
      axi.s_axi_rready = 1'b1;
    end
    wait_idle();
  endtask

  task automatic check_reset_outputs();
    chk("rst_awready", axi.s_axi_awready, 1'b0);
    chk("rst_wready", axi.s_axi_wready, 1'b0);
    chk("rst_arready", axi.s_axi_arready, 1'b0);
    chk("rst_bvalid", axi.s_axi_bvalid, 1'b0);
    chk("rst_bresp", axi.s_axi_bresp, 2'b00);
    chk("rst_bid", axi.s_axi_bid, '0);
    chk("rst_rvalid", axi.s_axi_rvalid, 1'b0);
    chk("rst_rlast", axi.s_axi_rlast, 1'b0);
    chk("rst_rresp", axi.s_axi_rresp, 2'b00);
    chk("rst_rid", axi.s_axi_rid, '0);
    chk("rst_rdata", axi.s_axi_rdata, '0);
    chk("rst_fifo_en", fifo_wr_en, 1'b0);
    chk("rst_fifo_data", fifo_wr_data, '0);
    chk("rst_turn2run", turn2run, 1'b0);
    chk("rst_state", debug_state, 3'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int pc0;
    axi.s_axi_awid = '0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0; axi.s_axi_wstrb = '1; axi.s_axi_wlast = 1'b0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b1;
    axi.s_axi_arid = '0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0; axi.s_axi_arvalid = 1'b0;
    axi.s_axi_rready = 1'b1;
    fifo_full = 1'b0; fifo_almost_full = 1'b0;
    // Register 1 (X) in the upper word, register 0 (Y) in the lower word.
    syn_regs = {128'h1111_2222_3333_4444_5555_6666_7777_8888,
                128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0123};

    repeat (3) tick();
    check_reset_outputs();
    rst_n = 1'b1;
    repeat (5) tick();

    // Single write.
    write_burst(16'h0042, 12'h000, 0, -1, -1, {16{8'hA5}});
    // 4-beat burst with almost_full raised for 5 cycles after beat 2.
    write_burst(16'h0007, 12'h010, 3, -1, 1, 128'h0BAD_F00D_0000_0000_1234_5678_9ABC_DEF0);
    // Trigger register.
    pc0 = pulse_cnt;
    write_burst(16'h0011, TRIG_A, 0, -1, -1, 128'h5A5A);
    chk("pulse_count", pulse_cnt, pc0 + 1);
    // Trigger register burst: one pulse, SLVERR.
    pc0 = pulse_cnt;
    write_burst(16'h0012, TRIG_A, 2, -1, -1, 128'h6B6B);
    chk("pulse_count_burst", pulse_cnt, pc0 + 1);
    // Two-beat read with R backpressure.
    read_burst(16'h0033, 12'h000, 1, 1'b1);
    // Out-of-range read.
    read_burst(16'h0034, 12'h020, 0, 1'b0);

    // AW and AR together, then reset in the middle of the W burst.
    expect_push = 1'b1;
    axi.s_axi_awid = 16'h0055; axi.s_axi_awaddr = 12'h040; axi.s_axi_awlen = 8'd2;
    axi.s_axi_arid = 16'h0066; axi.s_axi_araddr = 12'h000; axi.s_axi_arlen = 8'd0;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_arvalid = 1'b1;
    @(negedge clk);
    chk("aw_first", axi.s_axi_awready, 1'b1);
    chk("ar_wait", axi.s_axi_arready, 1'b0);
    tick();
    axi.s_axi_awvalid = 1'b0;
    w_send(128'hCAFE_0001, 1'b0, 1'b1);
    @(negedge clk);
    chk("ar_blocked", axi.s_axi_arready, 1'b0);
    tick();
    axi.s_axi_arvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    q_fifo.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    read_burst(16'h0077, 12'h010, 0, 1'b0);

    // wlast asserted early on beat 1 of a 3-beat burst.
    write_burst(16'h0099, 12'h000, 2, 1, -1, 128'hEA21_0000);
    // Longest burst: 256 beats.
    write_burst(16'h00FF, 12'h000, 255, -1, -1, 128'hFF00_0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/encore_axi_bridge.md
Name: encore_axi_bridge

Overview:
- Parametrised AXI4 slave that bridges host writes into an external FIFO and exposes NUM_SYN cross-domain status registers for read-back.
- Provides a trigger register whose write produces a TRIG_CYCLES-wide turn2run pulse.
- Adds full AXI4 INCR bursts, ID echo on B and R, error responses and B/R backpressure.
- Sits between the host interconnect and the encore accelerator's command FIFO and status path.

Parameters:
- DATA_W, 128, AXI data width and FIFO word width (multiple of 32).
- ADDR_W, 12, AXI address width.
- ID_W, 16, AXI ID width.
- NUM_SYN, 2, number of readable status registers (1..16).
- SYN_STAGES, 2, synchroniser depth for status inputs (>=2).
- TRIG_ADDR, 'h080, write address of the trigger register.
- TRIG_CYCLES, 3, turn2run pulse length in clocks (>=1).

Ports:
- s_axi_aclk  in  1  clock
- s_axi_aresetn  in  1  asynchronous active-low reset
- s_axi_awid/awaddr/awlen/awvalid  in  ID_W/ADDR_W/8/1  write address; burst type treated as INCR full-width
- s_axi_awready  out  1
- s_axi_wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1  write data; wstrb ignored
- s_axi_wready  out  1
- s_axi_bid/bresp/bvalid  out  ID_W/2/1;  s_axi_bready  in  1
- s_axi_arid/araddr/arlen/arvalid  in  ID_W/ADDR_W/8/1
- s_axi_arready  out  1
- s_axi_rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1;  s_axi_rready  in  1
- fifo_full, fifo_almost_full  in  1  FIFO status
- fifo_wr_data  out  DATA_W;  fifo_wr_en  out  1
- syn_regs  in  NUM_SYN*DATA_W  asynchronous status words, register k at bits [k*DATA_W +: DATA_W]
- turn2run  out  1  trigger pulse
- debug_state  out  3  current FSM state encoding

Behaviour:
- Reset (async assert, sync release): all ready/valid/en outputs 0, bresp/rresp 0, bid/rid/rdata/fifo_wr_data 0, turn2run 0, sync flops 0, state IDLE.
- Reset mid-transaction abandons the transaction. turn2run drops immediately. No partial B or R is ever issued.
- Status sync: each syn_regs word passes SYN_STAGES flops. Reads return the last stage.
- FSM states: IDLE=0, WR_DATA=1, WR_RESP=2, TRIG=3, RD_DATA=4.
- IDLE:
  - awvalid wins over arvalid when both are high.
  - On awvalid: assert awready for exactly 1 cycle. Latch awid, awaddr and awlen into beat counter cnt=0, and set err=0.
  - Next state is TRIG if awaddr==TRIG_ADDR, else WR_DATA.
  - On arvalid only: arready for 1 cycle. Latch arid, idx=araddr/(DATA_W/8) and len. Go to RD_DATA.
- WR_DATA:
  - wready = !fifo_full && !fifo_almost_full, driven from registered state.
  - Each W handshake registers fifo_wr_data=wdata and fifo_wr_en=1 for exactly one cycle. Latency from handshake to fifo_wr_en is 1 clock.
  - cnt increments per beat.
  - If wlast disagrees with (cnt==awlen), set err=1.
  - Leave after the beat with cnt==awlen, not on wlast. Further beats from a misbehaving master stall.
- TRIG:
  - Accept one W beat with wready=1 regardless of FIFO state. Data is not pushed.
  - turn2run rises the cycle after the handshake and stays high exactly TRIG_CYCLES clocks.
  - Then go to WR_RESP.
  - A burst (awlen!=0) to TRIG_ADDR: all beats are accepted and discarded, one pulse is issued, and bresp=SLVERR.
- WR_RESP: bvalid=1, bid=latched awid, bresp = err ? 2'b10 : 2'b00. Hold until bready, then IDLE (bvalid low the cycle after handshake).
- RD_DATA:
  - Per beat, rdata = (idx<NUM_SYN) ? sync[idx] : 0, and rresp = (idx<NUM_SYN) ? OKAY : SLVERR.
  - rid = latched arid; rlast=1 on beat len.
  - rvalid and rdata stay stable until rready. The next beat is presented the cycle after the handshake, with idx+1.
  - Return to IDLE after the last handshake.
- fifo_full asserting mid-burst drops wready the next cycle. No beat is lost and no push happens while fifo_full=1.
- Counters are 8-bit. awlen=255 gives 256 beats with no wrap error.
- No new AW or AR is accepted until the current transaction's B or last R handshake completes.

Decomposition:
- Package encore_axi_pkg: state enum (IDLE..RD_DATA), RESP_OKAY=2'b00, RESP_SLVERR=2'b10, function clog2.
- Sub-module encore_sync_pipe (params WIDTH, STAGES; async active-low reset), instantiated once per status word.

Test Plan:
- Single write, awaddr='h000, data 'hA5..A5, bready=1:
  - fifo_wr_en is one pulse 1 clk after the W handshake, with fifo_wr_data='hA5..A5.
  - bresp=0, bid equals awid='h0042.
- 4-beat burst, awlen=3, with fifo_almost_full forced high for 5 cycles after beat 2:
  - exactly 4 pushes, in order, none while the flag is high.
  - single B with bresp=OKAY.
- Write to 'h080:
  - turn2run high exactly 3 clks.
  - no FIFO push; bvalid only after the pulse ends.
- Read burst araddr='h000, arlen=1, syn_regs={X,Y} held stable >SYN_STAGES+1 clks:
  - R beats are Y then X, with rlast on beat 2 and rresp OKAY.
  - rready low for 3 cycles holds rdata stable.
- Read araddr='h020 with NUM_SYN=2: rdata=0, rresp=SLVERR, rlast=1.
- awvalid and arvalid asserted together, then reset asserted mid-W burst:
  - the write is served first.
  - after reset, all outputs are 0 and the next read completes normally.
- wlast early on beat 1 of awlen=2: 3 beats are pushed and bresp=SLVERR.
